// File: rtl/control_adv.sv
// User-control unit for the clock/calendar: synchronises and debounces the
// push buttons, generates up/down pulses with auto-repeat, steps through the
// editable items and leaves edit mode on inactivity.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_COUNT   | counters run, display group follows dis_sel
// S_EDIT    | counters stopped, select_item blinks, buttons act on it
// S_LOCKOUT | edit timed out; wait for mode_sel low before allowing re-entry
module control_adv #(
  parameter int NUM_ITEMS    = 6,
  parameter int ITEM_W       = 3,
  parameter int TIME_ITEMS   = 3,
  parameter int DEB_CYCLES   = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int TIMEOUT_CYC  = 500000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dis_sel,
  input  logic              mode_sel,
  input  logic              adjust,
  input  logic              up_btn,
  input  logic              down_btn,
  output logic              en_1,
  output logic              dem_chinh,
  output logic              smh_dmy,
  output logic [ITEM_W-1:0] select_item,
  output logic              blink_en,
  output logic              up,
  output logic              down,
  output logic              timeout
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0]  DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ITEM_W-1:0] SEL_LAST   = ITEM_W'(NUM_ITEMS - 1);
  localparam logic [ITEM_W-1:0] SEL_DATE   = ITEM_W'(TIME_ITEMS);

  typedef enum logic [1:0] {S_COUNT, S_EDIT, S_LOCKOUT} state_t;

  // bit order: 4 down, 3 up, 2 adjust, 1 mode_sel, 0 dis_sel
  logic [4:0]        sync1_q, sync2_q;
  // button order: 2 down, 1 up, 0 adjust
  logic [2:0]        btn_s, filt_q, filt_d, prev_q, press;
  logic [DEB_W-1:0]  deb_cnt_q [3];
  logic [DEB_W-1:0]  deb_cnt_d [3];
  // repeat order: 1 down, 0 up
  logic [1:0]        act_q, act_d, fire;
  logic [REP_W-1:0]  rep_q [2];
  logic [REP_W-1:0]  rep_d [2];
  logic [TMO_W-1:0]  idle_q, idle_d;
  state_t            state_q, state_d;
  logic [ITEM_W-1:0] sel_q, sel_d;
  logic              en_q, en_d, dem_q, dem_d, smh_q, smh_d, blink_q, blink_d;
  logic              up_q, up_d, down_q, down_d, timeout_q, timeout_d;
  logic              mode_s, dis_s, edit_stay, activity;

  assign btn_s  = sync2_q[4:2];
  assign mode_s = sync2_q[1];
  assign dis_s  = sync2_q[0];
  assign press  = filt_q & ~prev_q;
  // pulses only while EDIT persists; a falling mode_sel takes priority
  assign edit_stay = (state_q == S_EDIT) && mode_s;

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing cycles
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      filt_d[i]    = filt_q[i];
      deb_cnt_d[i] = '0;
      if (btn_s[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) filt_d[i] = btn_s[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Auto-repeat: first pulse on press, then after the delay, then at the rate.
  // Both buttons held disarms both, so the survivor needs a fresh press.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      fire[j]  = 1'b0;
      act_d[j] = act_q[j];
      rep_d[j] = rep_q[j];
      if (!edit_stay || !filt_q[j+1] || filt_q[2-j]) begin
        act_d[j] = 1'b0;
        rep_d[j] = '0;
      end else if (press[j+1]) begin
        fire[j]  = 1'b1;
        act_d[j] = 1'b1;
        rep_d[j] = DELAY_LAST;
      end else if (act_q[j]) begin
        if (rep_q[j] == '0) begin
          fire[j]  = 1'b1;
          rep_d[j] = RATE_LAST;
        end else begin
          rep_d[j] = rep_q[j] - 1'b1;
        end
      end
    end
  end

  // Mode FSM, inactivity timer, item selector and registered output values
  always_comb begin
    activity  = (|press) || (|fire);
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      S_COUNT:   if (mode_s) state_d = S_EDIT;
      S_EDIT: begin
        if (!mode_s) begin
          state_d = S_COUNT;
        end else if (idle_q == TMO_LAST && !activity) begin
          state_d   = S_LOCKOUT;
          timeout_d = 1'b1;
        end
      end
      S_LOCKOUT: if (!mode_s) state_d = S_COUNT;
      default:   state_d = S_COUNT;
    endcase

    idle_d = '0;
    if (state_q == S_EDIT && state_d == S_EDIT && !activity) idle_d = idle_q + 1'b1;

    sel_d = sel_q;
    if (state_d != S_EDIT)                 sel_d = '0;
    else if (edit_stay && press[0])        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

    en_d    = (state_d != S_EDIT);
    dem_d   = (state_d == S_EDIT);
    blink_d = (state_d == S_EDIT);
    smh_d   = (state_d == S_EDIT) ? (sel_d >= SEL_DATE) : dis_s;
    up_d    = fire[0];
    down_d  = fire[1];
  end

  // All state and output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      act_q     <= '0;
      for (int j = 0; j < 2; j++) rep_q[j] <= '0;
      idle_q    <= '0;
      state_q   <= S_COUNT;
      sel_q     <= '0;
      en_q      <= 1'b1;
      dem_q     <= 1'b0;
      smh_q     <= 1'b0;
      blink_q   <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= {down_btn, up_btn, adjust, mode_sel, dis_sel};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      prev_q    <= filt_q;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      act_q     <= act_d;
      for (int j = 0; j < 2; j++) rep_q[j] <= rep_d[j];
      idle_q    <= idle_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      dem_q     <= dem_d;
      smh_q     <= smh_d;
      blink_q   <= blink_d;
      up_q      <= up_d;
      down_q    <= down_d;
      timeout_q <= timeout_d;
    end
  end

  assign en_1        = en_q;
  assign dem_chinh   = dem_q;
  assign smh_dmy     = smh_q;
  assign select_item = sel_q;
  assign blink_en    = blink_q;
  assign up          = up_q;
  assign down        = down_q;
  assign timeout     = timeout_q;

endmodule
